// File: rtl/period_counter_if.sv
// Control and status bundle between the period counter and its controller.
// cnt is also the live operand handed to the downstream comparator.
interface period_counter_if #(
   parameter int N = 4
);
   logic         start;
   logic         stop;
   logic         mode;
   logic         dir;
   logic [N-1:0] load_val;
   logic [N-1:0] cnt;
   logic         running;
   logic         done;
   logic         tc_pulse;

   modport master (
      output start, stop, mode, dir, load_val,
      input  cnt, running, done, tc_pulse
   );

   modport slave (
      input  start, stop, mode, dir, load_val,
      output cnt, running, done, tc_pulse
   );
endinterface

// File: rtl/period_counter.sv
// Programmable up/down period counter with one-shot or auto-reload operation
// and a terminal-count pulse; all outputs come straight from flops.
module period_counter #(
   parameter int N = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   period_counter_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] period_q, period_d;
   logic         mode_q, mode_d;
   logic         dir_q, dir_d;
   logic         tc_q, tc_d;

   logic [N-1:0] step_v;
   logic [N-1:0] start_v;
   logic [N-1:0] reload_v;
   logic         term_v;
   logic         zero_p;

   assign step_v   = dir_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
   assign term_v   = dir_q ? (step_v == '0) : (step_v == period_q);
   assign start_v  = bus.dir ? bus.load_val : '0;
   assign reload_v = dir_q ? bus.load_val : '0;
   // A zero period is terminal immediately in both directions.
   assign zero_p   = (bus.load_val == '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      mode_d   = mode_q;
      dir_d    = dir_q;
      tc_d     = 1'b0;
      if (bus.stop) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  mode_d   = bus.mode;
                  dir_d    = bus.dir;
                  period_d = bus.load_val;
                  cnt_d    = start_v;
                  tc_d     = zero_p;
                  state_d  = (zero_p && !bus.mode) ? DONE : RUN;
               end
            end
            RUN: begin
               // Terminal held last cycle: only auto-reload can still be here.
               if (tc_q) begin
                  period_d = bus.load_val;
                  cnt_d    = reload_v;
                  tc_d     = zero_p;
               end else begin
                  cnt_d = step_v;
                  tc_d  = term_v;
                  if (term_v && !mode_q) state_d = DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         mode_q   <= 1'b0;
         dir_q    <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         dir_q    <= dir_d;
         tc_q     <= tc_d;
      end
   end

   assign bus.cnt      = cnt_q;
   assign bus.running  = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.tc_pulse = tc_q;
endmodule

// File: tb/tb_period_counter.sv
// Scoreboard bench for period_counter: stimulus queues expected outputs,
// a monitor compares them one cycle-edge later.
module tb_period_counter;
   localparam int N = 4;

   typedef struct {
      int           id;
      logic [N-1:0] cnt;
      logic         run;
      logic         done;
      logic         tc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   step_id;
   exp_t sb[$];

   period_counter_if #(.N(N)) bus ();

   period_counter #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(
      input logic         st,
      input logic         sp,
      input logic         md,
      input logic         dr,
      input logic [N-1:0] lv,
      input logic [N-1:0] e_cnt,
      input logic         e_run,
      input logic         e_done,
      input logic         e_tc
   );
      exp_t e;
      @(negedge clk);
      bus.start    = st;
      bus.stop     = sp;
      bus.mode     = md;
      bus.dir      = dr;
      bus.load_val = lv;
      e.id   = step_id;
      e.cnt  = e_cnt;
      e.run  = e_run;
      e.done = e_done;
      e.tc   = e_tc;
      sb.push_back(e);
      step_id++;
   endtask

   task automatic check_now(
      input string        name,
      input logic [N-1:0] e_cnt,
      input logic         e_run,
      input logic         e_done,
      input logic         e_tc
   );
      tests++;
      if (bus.cnt !== e_cnt || bus.running !== e_run ||
          bus.done !== e_done || bus.tc_pulse !== e_tc) begin
         fails++;
         $display("FAIL %s: got cnt=%0d run=%b done=%b tc=%b want cnt=%0d run=%b done=%b tc=%b",
                  name, bus.cnt, bus.running, bus.done, bus.tc_pulse,
                  e_cnt, e_run, e_done, e_tc);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (bus.cnt !== e.cnt || bus.running !== e.run ||
                bus.done !== e.done || bus.tc_pulse !== e.tc) begin
               fails++;
               $display("FAIL step%0d: got cnt=%0d run=%b done=%b tc=%b want cnt=%0d run=%b done=%b tc=%b",
                        e.id, bus.cnt, bus.running, bus.done, bus.tc_pulse,
                        e.cnt, e.run, e.done, e.tc);
            end
         end
      end
   end

   initial begin : stim
      tests   = 0;
      fails   = 0;
      step_id = 0;
      rst_n   = 1'b0;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.mode     = 1'b0;
      bus.dir      = 1'b0;
      bus.load_val = '0;
      #12;
      check_now("reset", 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // one-shot up, P=3
      step(1, 0, 0, 0, 4'd3, 4'd0, 1, 0, 0);
      step(0, 0, 0, 0, 4'd3, 4'd1, 1, 0, 0);
      step(0, 0, 0, 0, 4'd3, 4'd2, 1, 0, 0);
      step(0, 0, 0, 0, 4'd3, 4'd3, 0, 1, 1);
      step(0, 0, 0, 0, 4'd3, 4'd3, 0, 1, 0);
      step(0, 0, 0, 0, 4'd3, 4'd3, 0, 1, 0);

      // auto-reload down, P=2 then 5
      step(1, 0, 1, 1, 4'd2, 4'd2, 1, 0, 0);
      step(0, 0, 0, 0, 4'd5, 4'd1, 1, 0, 0);
      step(0, 0, 0, 0, 4'd5, 4'd0, 1, 0, 1);
      step(0, 0, 0, 0, 4'd5, 4'd5, 1, 0, 0);
      step(0, 0, 0, 0, 4'd5, 4'd4, 1, 0, 0);
      step(0, 0, 0, 0, 4'd5, 4'd3, 1, 0, 0);
      step(0, 0, 0, 0, 4'd5, 4'd2, 1, 0, 0);
      step(0, 0, 0, 0, 4'd5, 4'd1, 1, 0, 0);
      step(0, 0, 0, 0, 4'd5, 4'd0, 1, 0, 1);
      step(0, 0, 0, 0, 4'd5, 4'd5, 1, 0, 0);
      step(0, 1, 0, 0, 4'd5, 4'd5, 0, 0, 0);

      // zero period: auto-reload then one-shot
      step(1, 0, 1, 0, 4'd0, 4'd0, 1, 0, 1);
      step(0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 1);
      step(0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 1);
      step(0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 1);
      step(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0);
      step(1, 0, 0, 0, 4'd0, 4'd0, 0, 1, 1);
      step(0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0);

      // start+stop together at cnt=2, then plain restart
      step(1, 0, 0, 0, 4'd9, 4'd0, 1, 0, 0);
      step(0, 0, 0, 0, 4'd9, 4'd1, 1, 0, 0);
      step(0, 0, 0, 0, 4'd9, 4'd2, 1, 0, 0);
      step(1, 1, 0, 0, 4'd9, 4'd2, 0, 0, 0);
      step(1, 0, 0, 0, 4'd9, 4'd0, 1, 0, 0);
      step(0, 0, 0, 0, 4'd9, 4'd1, 1, 0, 0);

      // changes during RUN are ignored
      step(0, 1, 0, 0, 4'd9, 4'd1, 0, 0, 0);
      step(1, 0, 0, 0, 4'd4, 4'd0, 1, 0, 0);
      step(1, 0, 1, 1, 4'd7, 4'd1, 1, 0, 0);
      step(0, 0, 0, 1, 4'd2, 4'd2, 1, 0, 0);
      step(1, 0, 1, 0, 4'd1, 4'd3, 1, 0, 0);
      step(0, 0, 1, 1, 4'd6, 4'd4, 0, 1, 1);
      step(0, 0, 0, 0, 4'd6, 4'd4, 0, 1, 0);

      // async reset mid-count at cnt=7
      step(0, 1, 0, 0, 4'd15, 4'd4, 0, 0, 0);
      step(1, 0, 0, 0, 4'd15, 4'd0, 1, 0, 0);
      for (int i = 1; i <= 7; i++) begin
         step(0, 0, 0, 0, 4'd15, 4'(i), 1, 0, 0);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_now("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 4'd15, 4'd0, 0, 0, 0);
      step(1, 0, 0, 1, 4'd3, 4'd3, 1, 0, 0);
      step(0, 0, 0, 0, 4'd3, 4'd2, 1, 0, 0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
